m2_input_buffer_v2: RTL and testbench

- Parametrised ping-pong input buffer feeding the polyphase channelizer filter bank. Successor to the fixed M/2 buffer.
- Adds run-time selection of M/2 (overlapped) or M (critically sampled) mode and a generic maximum FFT size.
- Adds credit-based output flow control with an integrated output FIFO, plus `tlast`/phase tagging per output frame.
- Sits between the sample input stream and the PFB/FFT path; one output frame of M samples per input block.

---
 rtl/m2_input_buffer_v2.sv | 205 ++++++++++++++++++++
 tb/tb_m2_input_buffer_v2.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m2_input_buffer_v2.sv
// rtl/m2_input_buffer_v2.sv - ping-pong input buffer (M/2 overlapped or M critical) with credit-gated reads and output FIFO
module m2_input_buffer_v2 #(
  parameter int DATA_WIDTH     = 32,
  parameter int FFT_SIZE_WIDTH = 12,
  parameter int RAM_LATENCY    = 3,
  parameter int OUT_FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      sync_reset_n,
  input  logic                      s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  output logic                      s_axis_tready,
  input  logic [FFT_SIZE_WIDTH-1:0] fft_size,
  input  logic                      mode,
  output logic                      m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic [FFT_SIZE_WIDTH-2:0] phase,
  input  logic                      m_axis_tready,
  output logic                      busy
);

  localparam int AW = FFT_SIZE_WIDTH - 1;
  localparam int RL = RAM_LATENCY;
  localparam int FW = $clog2(OUT_FIFO_DEPTH);
  localparam int CW = $clog2(OUT_FIFO_DEPTH + RAM_LATENCY + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_PASS0, S_PASS1} state_t;

  logic [FFT_SIZE_WIDTH-1:0] cfg_m;
  logic                      cfg_mode;
  logic [AW-1:0]             half_m;
  logic [AW-1:0]             blk_last;

  logic                      running;
  logic                      wbank;
  logic [AW-1:0]             wcnt;
  logic [1:0]                bank_full;
  logic                      in_hs;
  logic                      wr_fill;

  state_t                    state;
  state_t                    state_nxt;
  logic                      rbank;
  logic [AW-1:0]             rcnt;
  logic                      other_ready;
  logic                      credit_ok;
  logic                      issue;
  logic                      frame_end;
  logic [AW-1:0]             iss_phase;
  logic [CW-1:0]             inflight;

  logic [RL-1:0]             p_valid;
  logic [RL-1:0]             p_last;
  logic [AW-1:0]             p_phase [RL];
  logic [AW-1:0]             p_addr;
  logic                      p_bank;
  logic [DATA_WIDTH-1:0]     d_pipe [1:RL-1];
  logic [DATA_WIDTH-1:0]     mem [2*(2**AW)];

  logic [DATA_WIDTH-1:0]     f_data  [OUT_FIFO_DEPTH];
  logic [AW-1:0]             f_phase [OUT_FIFO_DEPTH];
  logic                      f_last  [OUT_FIFO_DEPTH];
  logic [FW-1:0]             f_wptr;
  logic [FW-1:0]             f_rptr;
  logic [FW:0]               fifo_count;
  logic                      push;
  logic                      pop;

  assign half_m   = cfg_m[AW:1];
  assign blk_last = cfg_mode ? (cfg_m[AW-1:0] - AW'(1)) : (half_m - AW'(1));

  assign s_axis_tready = running && !bank_full[wbank];
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign wr_fill       = in_hs && (wcnt == blk_last);

  // A bank completing on the same edge the reader finishes counts as ready, so continuous input never idles the reader.
  assign other_ready = bank_full[~rbank] || (wr_fill && (wbank != rbank));

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RL; i++) inflight = inflight + CW'(p_valid[i]);
  end

  assign credit_ok = (CW'(fifo_count) + inflight) < CW'(OUT_FIFO_DEPTH);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    frame_end = 1'b0;
    iss_phase = (state == S_PASS1) ? (half_m + rcnt) : rcnt;
    case (state)
      S_IDLE: begin
        if (bank_full[rbank]) state_nxt = S_PASS0;
      end
      S_PASS0, S_PASS1: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (rcnt == blk_last) begin
            if (state == S_PASS0 && !cfg_mode) begin
              state_nxt = S_PASS1;
            end else begin
              frame_end = 1'b1;
              state_nxt = other_ready ? S_PASS0 : S_IDLE;
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (|bank_full) || (wcnt != '0) || (state != S_IDLE) || (|p_valid);

  always_ff @(posedge clk or negedge sync_reset_n) begin
    if (!sync_reset_n) begin
      running   <= 1'b0;
      wcnt      <= '0;
      wbank     <= 1'b0;
      bank_full <= 2'b00;
      cfg_m     <= FFT_SIZE_WIDTH'(8);
      cfg_mode  <= 1'b0;
    end else begin
      running <= 1'b1;
      if (!busy && !in_hs) begin
        cfg_m    <= fft_size;
        cfg_mode <= mode;
      end
      if (in_hs) begin
        if (wr_fill) begin
          wcnt  <= '0;
          wbank <= ~wbank;
        end else begin
          wcnt <= wcnt + AW'(1);
        end
      end
      if (wr_fill)   bank_full[wbank] <= 1'b1;
      if (frame_end) bank_full[rbank] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge sync_reset_n) begin
    if (!sync_reset_n) begin
      state   <= S_IDLE;
      rbank   <= 1'b0;
      rcnt    <= '0;
      p_valid <= '0;
      p_last  <= '0;
      p_addr  <= '0;
      p_bank  <= 1'b0;
      for (int i = 0; i < RL; i++) p_phase[i] <= '0;
    end else begin
      state <= state_nxt;
      if (issue) rcnt <= (rcnt == blk_last) ? '0 : rcnt + AW'(1);
      if (frame_end) rbank <= ~rbank;
      p_valid    <= {p_valid[RL-2:0], issue};
      p_last     <= {p_last[RL-2:0], frame_end};
      p_phase[0] <= iss_phase;
      for (int i = 1; i < RL; i++) p_phase[i] <= p_phase[i-1];
      p_addr <= rcnt;
      p_bank <= rbank;
    end
  end

  // Read-first: a write landing on the edge that reads the same word returns the old contents.
  always_ff @(posedge clk) begin
    if (in_hs) mem[{wbank, wcnt}] <= s_axis_tdata;
    d_pipe[1] <= mem[{p_bank, p_addr}];
    for (int i = 2; i < RL; i++) d_pipe[i] <= d_pipe[i-1];
  end

  assign push = p_valid[RL-1];
  assign pop  = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (push) begin
      f_data[f_wptr]  <= d_pipe[RL-1];
      f_phase[f_wptr] <= p_phase[RL-1];
      f_last[f_wptr]  <= p_last[RL-1];
    end
  end

  always_ff @(posedge clk or negedge sync_reset_n) begin
    if (!sync_reset_n) begin
      f_wptr     <= '0;
      f_rptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) f_wptr <= f_wptr + FW'(1);
      if (pop)  f_rptr <= f_rptr + FW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (FW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (FW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Outputs are gated so they read as zero whenever nothing is presented, including straight out of reset.
  assign m_axis_tvalid = (fifo_count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? f_data[f_rptr]  : '0;
  assign phase         = m_axis_tvalid ? f_phase[f_rptr] : '0;
  assign m_axis_tlast  = m_axis_tvalid ? f_last[f_rptr]  : 1'b0;

endmodule

// File: tb/tb_m2_input_buffer_v2.sv
// tb/tb_m2_input_buffer_v2.sv - randomized scoreboard bench for m2_input_buffer_v2
module tb_m2_input_buffer_v2;

  localparam int DW     = 32;
  localparam int FSW    = 12;
  localparam int RLAT   = 3;
  localparam int ODEPTH = 8;

  logic           clk;
  logic           sync_reset_n;
  logic           s_axis_tvalid;
  logic [DW-1:0]  s_axis_tdata;
  logic           s_axis_tready;
  logic [FSW-1:0] fft_size;
  logic           mode;
  logic           m_axis_tvalid;
  logic [DW-1:0]  m_axis_tdata;
  logic           m_axis_tlast;
  logic [FSW-2:0] phase;
  logic           m_axis_tready;
  logic           busy;

  m2_input_buffer_v2 #(
    .DATA_WIDTH(DW), .FFT_SIZE_WIDTH(FSW), .RAM_LATENCY(RLAT), .OUT_FIFO_DEPTH(ODEPTH)
  ) dut (
    .clk(clk), .sync_reset_n(sync_reset_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
    .fft_size(fft_size), .mode(mode),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .phase(phase), .m_axis_tready(m_axis_tready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            in_prob = 100;
  int            rdy_prob = 100;
  int            mdl_m   = 16;
  bit            mdl_mode = 1'b0;
  int            n_acc, n_out, fill_cyc, first_out_cyc, last_out_cyc;
  logic [DW-1:0] to_send [$];
  logic [DW-1:0] blk [$];
  logic [DW-1:0] exp_data [$];
  int            exp_phase [$];
  bit            exp_last [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int blk_len();
    return mdl_mode ? mdl_m : mdl_m / 2;
  endfunction

  // One clock: drive at negedge, judge both handshakes just before the rising edge.
  task automatic cycle();
    @(negedge clk);
    s_axis_tvalid = (to_send.size() != 0) && ($urandom_range(99) < in_prob);
    s_axis_tdata  = (to_send.size() != 0) ? to_send[0] : '0;
    m_axis_tready = ($urandom_range(99) < rdy_prob);
    #1;
    if (s_axis_tvalid && s_axis_tready) begin
      blk.push_back(to_send.pop_front());
      n_acc++;
      if (blk.size() == blk_len()) begin
        if (fill_cyc < 0) fill_cyc = cyc;
        for (int p = 0; p < mdl_m; p++) begin
          exp_data.push_back(blk[p % blk_len()]);
          exp_phase.push_back(p);
          exp_last.push_back(p == mdl_m - 1);
        end
        blk.delete();
      end
    end
    if (m_axis_tvalid && first_out_cyc < 0) first_out_cyc = cyc;
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_data.size() == 0) begin
        check_eq("unexpected_output", 64'd1, 64'd0);
      end else begin
        check_eq("data", m_axis_tdata, exp_data.pop_front());
        check_eq("phase", phase, exp_phase.pop_front());
        check_eq("tlast", m_axis_tlast, exp_last.pop_front());
      end
      n_out++;
      last_out_cyc = cyc;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic start_run(input int m, input bit md);
    fft_size = FSW'(m);
    mode     = md;
    mdl_m    = m;
    mdl_mode = md;
    n_acc = 0; n_out = 0;
    fill_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
    for (int i = 0; i < 3; i++) cycle();
  endtask

  task automatic push_ramp(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) to_send.push_back(base + DW'(i));
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (!(to_send.size() == 0 && exp_data.size() == 0 && !busy) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) check_eq({tag, "_drain_timeout"}, 64'd1, 64'd0);
    check_eq({tag, "_left"}, exp_data.size(), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sync_reset_n  = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    fft_size      = FSW'(16);
    mode          = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tvalid", m_axis_tvalid, 0);
    check_eq("rst_tdata", m_axis_tdata, 0);
    check_eq("rst_tlast", m_axis_tlast, 0);
    check_eq("rst_phase", phase, 0);
    check_eq("rst_sready", s_axis_tready, 0);
    check_eq("rst_busy", busy, 0);
    sync_reset_n = 1'b1;
    #1;
    check_eq("rel_sready_low", s_axis_tready, 0);
    @(negedge clk);
    check_eq("rel_sready_high", s_axis_tready, 1);

    // Overlapped M=16 ramp; first output lands RAM_LATENCY+2 edges after the fill edge (cycle index adds one).
    in_prob = 100; rdy_prob = 100;
    start_run(16, 1'b0);
    push_ramp(0, 64);
    drain("t1", 2000);
    check_eq("t1_nout", n_out, 128);
    check_eq("t1_latency", first_out_cyc - fill_cyc, RLAT + 3);

    start_run(16, 1'b1);
    push_ramp(0, 48);
    drain("t2", 2000);
    check_eq("t2_nout", n_out, 48);
    check_eq("t2_no_gap", last_out_cyc - first_out_cyc, 47);
    check_eq("t2_latency", first_out_cyc - fill_cyc, RLAT + 3);

    start_run(2048, 1'b0);
    rdy_prob = 30;
    push_ramp($urandom, 3072);
    drain("t3", 40000);
    check_eq("t3_nout", n_out, 6144);

    start_run(64, 1'b1);
    in_prob = 60; rdy_prob = 70;
    for (int i = 0; i < 256; i++) to_send.push_back($urandom);
    drain("t3b", 4000);
    check_eq("t3b_nout", n_out, 256);

    // Stalled output: FIFO plus both banks absorb the input, then the writer must stop.
    in_prob = 100; rdy_prob = 0;
    start_run(8, 1'b1);
    push_ramp(0, 32);
    for (int i = 0; i < 200; i++) cycle();
    check_eq("t4_accepted", n_acc, ODEPTH + 2 * 8);
    @(negedge clk);
    check_eq("t4_sready", s_axis_tready, 0);
    check_eq("t4_nout_stalled", n_out, 0);
    rdy_prob = 100;
    drain("t4", 2000);
    check_eq("t4_nout", n_out, 32);
    check_eq("t4_acc_all", n_acc, 32);

    start_run(16, 1'b0);
    push_ramp(100, 24);
    for (int i = 0; i < 4; i++) cycle();
    fft_size = FSW'(32);
    drain("t5a", 2000);
    check_eq("t5a_nout", n_out, 48);
    start_run(32, 1'b0);
    push_ramp(200, 32);
    drain("t5b", 2000);
    check_eq("t5b_nout", n_out, 64);

    start_run(16, 1'b0);
    push_ramp(500, 32);
    begin
      int n = 0;
      while (n_out < 6 && n < 300) begin
        cycle();
        n++;
      end
      if (n >= 300) check_eq("t6_wait_timeout", 64'd1, 64'd0);
    end
    @(negedge clk);
    #2;
    sync_reset_n = 1'b0;
    #1;
    check_eq("t6_tvalid", m_axis_tvalid, 0);
    check_eq("t6_tdata", m_axis_tdata, 0);
    check_eq("t6_tlast", m_axis_tlast, 0);
    check_eq("t6_phase", phase, 0);
    check_eq("t6_sready", s_axis_tready, 0);
    check_eq("t6_busy", busy, 0);
    to_send.delete(); blk.delete();
    exp_data.delete(); exp_phase.delete(); exp_last.delete();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("t6_tvalid_held", m_axis_tvalid, 0);
    sync_reset_n = 1'b1;
    #1;
    check_eq("t6_rel_sready_low", s_axis_tready, 0);
    @(negedge clk);
    check_eq("t6_rel_sready_high", s_axis_tready, 1);
    start_run(16, 1'b0);
    push_ramp(0, 16);
    drain("t6", 2000);
    check_eq("t6_nout", n_out, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
